// File: rtl/sfp_link_reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// sfp_link_reset_sequencer_if
//   Bundles the per-channel status inputs and reset/ready outputs of the SFP
//   link reset sequencer.
//
//   Signals (N_CH channels):
//     RESETDONE  [N_CH]    transceiver resetdone (asynchronous to CLK)
//     LINK_UP    [N_CH]    PCS status_vector[0] (asynchronous to CLK)
//     PCS_RST    [N_CH]    reset to PCS/PMA core and mii_initializer
//     CH_READY   [N_CH]    channel is in the UP state
//     ALL_READY            registered AND of CH_READY
//     RETRY_CNT  [8*N_CH]  per-channel retry count, channel i at [8i+7:8i]
//     state_dbg  [3*N_CH]  per-channel FSM state, channel i at [3i+2:3i]
//
//   Modports:
//     master : transceiver/link side (drives status, observes sequencer)
//     slave  : the sequencer itself
//
//   There are no valid/ready handshakes here: every signal is a level that is
//   sampled each CLK cycle. The status inputs are asynchronous and are
//   synchronised inside the sequencer.
// ----------------------------------------------------------------------------
interface sfp_link_reset_sequencer_if #(
    parameter int N_CH = 1
);
    logic [N_CH-1:0]   RESETDONE;
    logic [N_CH-1:0]   LINK_UP;
    logic [N_CH-1:0]   PCS_RST;
    logic [N_CH-1:0]   CH_READY;
    logic              ALL_READY;
    logic [8*N_CH-1:0] RETRY_CNT;
    logic [3*N_CH-1:0] state_dbg;

    modport master (
        output RESETDONE, LINK_UP,
        input  PCS_RST, CH_READY, ALL_READY, RETRY_CNT, state_dbg
    );

    modport slave (
        input  RESETDONE, LINK_UP,
        output PCS_RST, CH_READY, ALL_READY, RETRY_CNT, state_dbg
    );
endinterface

// File: rtl/sfp_link_reset_sequencer.sv
// ----------------------------------------------------------------------------
// sfp_link_reset_sequencer
//   Per-channel reset / bring-up sequencer for N_CH 1000BASE-X PCS/PMA +
//   SiTCP links. Each channel independently waits a power-on delay, watches
//   for a RESETDONE rising edge, issues a one-shot PCS_RST pulse, supervises
//   LINK_UP with a timeout retry, and re-initialises on sustained link loss.
//
//   Ports:
//     CLK   system clock (125 MHz, rxuserclk2 domain)
//     RST   synchronous active-high reset
//     bus   sfp_link_reset_sequencer_if.slave
//             RESETDONE/LINK_UP in, PCS_RST/CH_READY/ALL_READY/RETRY_CNT out,
//             state_dbg exposes each channel's FSM state
//
//   Configuration macro: SFP_RETRY_COUNT_EN
//     defined   : 8-bit saturating retry counter per channel on RETRY_CNT
//     undefined : no counters are built, RETRY_CNT is tied to 0; the FSM
//                 retry transitions are identical in both builds
// ----------------------------------------------------------------------------
module sfp_link_reset_sequencer #(
    parameter int N_CH           = 1,
    parameter int POR_CYCLES     = 16,
    parameter int DELAY_CYCLES   = 4,
    parameter int PULSE_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1250000,
    parameter int LOSS_CYCLES    = 1250
) (
    input logic                      CLK,
    input logic                      RST,
    sfp_link_reset_sequencer_if.slave bus
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(POR_CYCLES, DELAY_CYCLES),
                                       max2(PULSE_CYCLES, TIMEOUT_CYCLES)),
                                  LOSS_CYCLES);
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] POR_LAST     = CW'(POR_CYCLES - 1);
    // The DELAY count runs 0..DELAY_CYCLES: together with the two sync
    // stages, the edge register and the FSM entry this puts the PCS_RST rise
    // DELAY_CYCLES+4 edges after RESETDONE is first sampled high.
    localparam logic [CW-1:0] DELAY_LAST   = CW'(DELAY_CYCLES);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] LOSS_LAST    = CW'(LOSS_CYCLES - 1);

    typedef enum logic [2:0] {
        S_POR       = 3'd0,
        S_WAIT_DONE = 3'd1,
        S_DELAY     = 3'd2,
        S_PULSE     = 3'd3,
        S_SETTLE    = 3'd4,
        S_UP        = 3'd5
    } state_t;

`ifdef SFP_RETRY_COUNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    logic [N_CH-1:0] pcs_vec;
    logic [N_CH-1:0] ready_vec;
    logic            all_ready_r;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t          state;
        logic [CW-1:0]   cnt;
        logic            done_s1, done_s2, done_d, done_rise;
        logic            link_s1, link_s2;
        logic            pcs_rst_r;
        logic            ready_r;
`ifdef SFP_RETRY_COUNT_EN
        logic [7:0]      retry_r;
`endif

        always_ff @(posedge CLK) begin
            if (RST) begin
                state     <= S_POR;
                cnt       <= '0;
                done_s1   <= 1'b0;
                done_s2   <= 1'b0;
                done_d    <= 1'b0;
                done_rise <= 1'b0;
                link_s1   <= 1'b0;
                link_s2   <= 1'b0;
                pcs_rst_r <= 1'b0;
                ready_r   <= 1'b0;
`ifdef SFP_RETRY_COUNT_EN
                retry_r   <= 8'd0;
`endif
            end else begin
                done_s1   <= bus.RESETDONE[i];
                done_s2   <= done_s1;
                done_d    <= done_s2;
                done_rise <= done_s2 & ~done_d;
                link_s1   <= bus.LINK_UP[i];
                link_s2   <= link_s1;

                case (state)
                    S_POR: begin
                        if (cnt == POR_LAST) begin
                            state <= S_WAIT_DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    // An edge that landed during POR is already gone from
                    // done_rise, so a level high on entry never counts.
                    S_WAIT_DONE: begin
                        if (done_rise) begin
                            state <= S_DELAY;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state     <= S_PULSE;
                            cnt       <= '0;
                            pcs_rst_r <= 1'b1;
`ifdef SFP_RETRY_COUNT_EN
                            retry_r   <= sat_inc(retry_r);
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DELAY: begin
                        if (cnt == DELAY_LAST) begin
                            state     <= S_PULSE;
                            cnt       <= '0;
                            pcs_rst_r <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_PULSE: begin
                        if (cnt == PULSE_LAST) begin
                            state     <= S_SETTLE;
                            cnt       <= '0;
                            pcs_rst_r <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    // RESETDONE edges are deliberately not looked at here.
                    S_SETTLE: begin
                        if (link_s2) begin
                            state   <= S_UP;
                            cnt     <= '0;
                            ready_r <= 1'b1;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state     <= S_PULSE;
                            cnt       <= '0;
                            pcs_rst_r <= 1'b1;
`ifdef SFP_RETRY_COUNT_EN
                            retry_r   <= sat_inc(retry_r);
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    // cnt is the consecutive-loss filter; any high sample
                    // restarts it.
                    S_UP: begin
                        if (link_s2) begin
                            cnt <= '0;
                        end else if (cnt == LOSS_LAST) begin
                            state     <= S_PULSE;
                            cnt       <= '0;
                            pcs_rst_r <= 1'b1;
                            ready_r   <= 1'b0;
`ifdef SFP_RETRY_COUNT_EN
                            retry_r   <= sat_inc(retry_r);
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= S_POR;
                        cnt       <= '0;
                        pcs_rst_r <= 1'b0;
                        ready_r   <= 1'b0;
                    end
                endcase
            end
        end

        assign pcs_vec[i]               = pcs_rst_r;
        assign ready_vec[i]             = ready_r;
        assign bus.state_dbg[3*i +: 3]  = state;
`ifdef SFP_RETRY_COUNT_EN
        assign bus.RETRY_CNT[8*i +: 8]  = retry_r;
`else
        assign bus.RETRY_CNT[8*i +: 8]  = 8'd0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            all_ready_r <= 1'b0;
        end else begin
            all_ready_r <= &ready_vec;
        end
    end

    assign bus.PCS_RST   = pcs_vec;
    assign bus.CH_READY  = ready_vec;
    assign bus.ALL_READY = all_ready_r;

endmodule
